// File: rtl/mux16to1_using_4to1.sv
// mux16to1_using_4to1: registered 16:1 bit selector built from five gate-level 4:1 cells
// mux4to1 returns d[{sa,sb}] using only NOT/AND/OR primitives.
module mux4to1 (
    output logic       y,
    input  logic [0:3] d,
    input  logic       sa,
    input  logic       sb
);
    logic na, nb, t0, t1, t2, t3;
    not (na, sa);
    not (nb, sb);
    and (t0, d[0], na, nb);
    and (t1, d[1], na, sb);
    and (t2, d[2], sa, nb);
    and (t3, d[3], sa, sb);
    or  (y, t0, t1, t2, t3);
endmodule

module mux16to1_using_4to1 (
    output logic        out,
    input  logic [0:15] in,
    input  logic        s0,
    input  logic        s1,
    input  logic        s2,
    input  logic        s3,
    input  logic        clk,
    input  logic        rst_n
);
    logic [0:3] m;
    logic       sel;
    for (genvar g = 0; g < 4; g++) begin : grp
        mux4to1 u_lvl1 (.y(m[g]), .d(in[4*g +: 4]), .sa(s2), .sb(s3));
    end
    mux4to1 u_lvl2 (.y(sel), .d(m), .sa(s0), .sb(s1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out <= 1'b0;
        else        out <= sel;
    end
endmodule

// File: tb/tb_mux16to1_using_4to1.sv
// tb_mux16to1_using_4to1: directed vectors with hand-computed expectations
module tb_mux16to1_using_4to1;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [0:15] din = '0;
    logic [3:0]  sel = '0;
    logic        out;
    int          checks = 0;
    int          failures = 0;

    mux16to1_using_4to1 dut (
        .out(out), .in(din), .s0(sel[3]), .s1(sel[2]), .s2(sel[1]), .s3(sel[0]),
        .clk(clk), .rst_n(rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [0:15] v, input logic [3:0] k);
        @(negedge clk);
        din = v;
        sel = k;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:15] grp;
        din = 16'hFFFF;
        sel = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("reset_hold", out, 1'b0);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1 check("reset_release", out, 1'b1);

        for (int k = 0; k < 16; k++) begin
            apply(16'h8000 >> k, 4'(k));
            check($sformatf("onehot_match_k%0d", k), out, 1'b1);
            for (int c = 0; c < 2; c++) begin
                @(posedge clk);
                #1 check($sformatf("onehot_hold_k%0d", k), out, 1'b1);
            end
        end

        for (int j = 0; j < 16; j++)
            for (int k = 0; k < 16; k++)
                if (j != k) begin
                    apply(16'h8000 >> j, 4'(k));
                    check($sformatf("onehot_miss_j%0d_k%0d", j, k), out, 1'b0);
                end

        grp = 16'b0000_1111_0000_1111;
        apply(grp, 4'd3);  check("group_k3",  out, 1'b0);
        apply(grp, 4'd4);  check("group_k4",  out, 1'b1);
        apply(grp, 4'd7);  check("group_k7",  out, 1'b1);
        apply(grp, 4'd8);  check("group_k8",  out, 1'b0);
        apply(grp, 4'd11); check("group_k11", out, 1'b0);
        apply(grp, 4'd12); check("group_k12", out, 1'b1);

        apply(16'h0000, 4'd5);
        check("latency_base", out, 1'b0);
        @(negedge clk);
        din = 16'h0400;
        #1 check("latency_no_comb", out, 1'b0);
        #3 check("latency_before_edge", out, 1'b0);
        @(posedge clk);
        #1 check("latency_after_edge", out, 1'b1);

        #1 rst_n = 0;
        #1 check("async_reset_immediate", out, 1'b0);
        #1 rst_n = 1;
        #1 check("async_reset_wait_edge", out, 1'b0);
        @(posedge clk);
        #1 check("async_reset_resume", out, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
